// File: rtl/spi_slave_ctrl_pkg.sv
// Shared types and helpers for the SPI-slave control FSM.
// Holds the state encoding and the frame geometry helpers used to size the bit counter.
package spi_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        LATCH     = 4'd2,
        RD_LOAD   = 4'd3,
        RD_OUT    = 4'd4,
        WR_DATA   = 4'd5,
        WR_COMMIT = 4'd6,
        INC       = 4'd7,
        DONE      = 4'd8
    } state_t;

    // Header is the address followed by the single R/W bit.
    function automatic int hdr_len(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int cnt_width(input int addr_w, input int data_w);
        int m;
        m = (hdr_len(addr_w) > data_w) ? hdr_len(addr_w) : data_w;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Bus between the input conditioners / datapath strobes and the SPI-slave control FSM.
// The slave modport is the controller view; dbg_state mirrors the FSM register for observation.
interface spi_slave_ctrl_if;
    import spi_ctrl_pkg::*;

    logic   cs;
    logic   sclk_rise;
    logic   sclk_fall;
    logic   rw_bit;
    logic   add_WE;
    logic   addr_inc;
    logic   DM_WE;
    logic   SR_WE;
    logic   MISO_Buff;
    logic   busy;
    logic   frame_err;
    state_t dbg_state;

    modport slave (
        input  cs, sclk_rise, sclk_fall, rw_bit,
        output add_WE, addr_inc, DM_WE, SR_WE, MISO_Buff, busy, frame_err, dbg_state
    );

    modport master (
        output cs, sclk_rise, sclk_fall, rw_bit,
        input  add_WE, addr_inc, DM_WE, SR_WE, MISO_Buff, busy, frame_err, dbg_state
    );

endinterface

// File: rtl/spi_slave_ctrl_bit_counter.sv
// Clearable up-counter with a terminal-count flag against a runtime limit.
// o_hit is high on the enabled cycle whose increment reaches i_limit.
module spi_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_cnt,
    output logic         o_hit
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + W'(1);
    assign o_hit     = i_en && (w_cnt_nxt == i_limit);
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI-slave control FSM: sequences address latch, memory write, shift-register load and
// MISO enable for each frame, with optional auto-increment bursts and abort detection.
module spi_slave_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter bit BURST_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    spi_slave_ctrl_if.slave  bus
);

    localparam int             CNT_W    = cnt_width(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] HDR_LIM  = CNT_W'(hdr_len(ADDR_W));
    localparam logic [CNT_W-1:0] DATA_LIM = CNT_W'(DATA_W);

    state_t           r_state;
    state_t           w_next;
    logic             r_mode_rd;
    logic             r_frame_err;
    logic             w_abort_err;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_hit;
    logic [CNT_W-1:0] w_limit;
    logic [CNT_W-1:0] w_cnt;

    // The counter restarts on every state change, so each counting state begins at zero.
    assign w_cnt_clr = reset || (w_next != r_state);
    assign w_limit   = (r_state == ADDR) ? HDR_LIM : DATA_LIM;
    assign w_cnt_en  = !bus.cs &&
                       ((((r_state == ADDR) || (r_state == WR_DATA)) && bus.sclk_rise) ||
                        ((r_state == RD_OUT) && bus.sclk_fall));

    spi_bit_counter #(.W(CNT_W)) u_bit_cnt (
        .clk     (clk),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (w_limit),
        .o_cnt   (w_cnt),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mode_rd   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_frame_err <= w_abort_err;
            if (r_state == LATCH) begin
                r_mode_rd <= bus.rw_bit;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_abort_err = 1'b0;
        if ((r_state != IDLE) && bus.cs) begin
            // A word boundary (count zero) in WR_DATA/RD_OUT is a clean burst end.
            w_next = IDLE;
            case (r_state)
                ADDR:            w_abort_err = (w_cnt != '0) || bus.sclk_rise;
                WR_DATA, RD_OUT: w_abort_err = (w_cnt != '0);
                default:         w_abort_err = 1'b0;
            endcase
        end else begin
            case (r_state)
                IDLE:      if (!bus.cs) w_next = ADDR;
                ADDR:      if (w_hit) w_next = LATCH;
                LATCH:     w_next = bus.rw_bit ? RD_LOAD : WR_DATA;
                RD_LOAD:   w_next = RD_OUT;
                RD_OUT:    if (w_hit) w_next = BURST_EN ? INC : DONE;
                WR_DATA:   if (w_hit) w_next = WR_COMMIT;
                WR_COMMIT: w_next = BURST_EN ? INC : DONE;
                INC:       w_next = r_mode_rd ? RD_LOAD : WR_DATA;
                DONE:      w_next = DONE;
                default:   w_next = IDLE;
            endcase
        end
    end

    assign bus.add_WE    = (r_state == LATCH);
    assign bus.SR_WE     = (r_state == RD_LOAD);
    assign bus.MISO_Buff = (r_state == RD_OUT);
    assign bus.DM_WE     = (r_state == WR_COMMIT);
    assign bus.addr_inc  = (r_state == INC);
    assign bus.busy      = (r_state != IDLE);
    assign bus.frame_err = r_frame_err;
    assign bus.dbg_state = r_state;

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
Parametrised SPI-slave control FSM in the clk domain. It sequences the address latch, data-memory write, shift-register parallel load and MISO tri-state buffer for SPI memory frames. It takes conditioned, one-cycle sclk edge pulses and a conditioned cs from the input conditioners. It adds configurable address and data widths, an auto-increment burst mode, abort detection and synchronous reset. It sits between the input conditioners and the address latch, data memory, shift register and MISO buffer.

Parameters:
ADDR_W, 7, address bits per frame; the R/W bit follows them, so the header is ADDR_W+1 bits.
DATA_W, 8, data bits per word.
BURST_EN, 1, 1 = auto-increment address and continue while cs stays low; 0 = one word per frame.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs  in  1  conditioned chip select, active low
sclk_rise  in  1  one-clk pulse on SPI clock rising edge
sclk_fall  in  1  one-clk pulse on SPI clock falling edge
rw_bit  in  1  shift register bit 0 (R/W flag; 1 = read)
add_WE  out  1  address latch write enable
addr_inc  out  1  address latch increment strobe
DM_WE  out  1  data memory write enable
SR_WE  out  1  shift register parallel-load enable
MISO_Buff  out  1  MISO tri-state enable
busy  out  1  state != IDLE
frame_err  out  1  one-clk pulse on aborted frame

Behaviour:
- Moore outputs, decoded from the registered state only.
- Reset:
  - State goes to IDLE and bit_cnt to 0.
  - All outputs are 0 on the cycle after reset is sampled high.
  - Reset mid-frame discards the frame; no DM_WE is issued.
- States and outputs:
  - IDLE: all outputs 0. Goes to ADDR on cs==0, with bit_cnt cleared.
  - ADDR: increments bit_cnt on each sclk_rise. On the rise that makes bit_cnt == ADDR_W+1, goes to LATCH.
  - LATCH: add_WE=1 for exactly 1 clk. Samples rw_bit: 1 goes to RD_LOAD, 0 goes to WR_DATA (bit_cnt cleared).
  - RD_LOAD: SR_WE=1 for exactly 1 clk, then goes to RD_OUT with bit_cnt cleared.
  - RD_OUT: MISO_Buff=1. Counts sclk_fall pulses. At DATA_W falls, goes to INC if BURST_EN, else DONE.
  - WR_DATA: counts sclk_rise pulses. At DATA_W rises, goes to WR_COMMIT.
  - WR_COMMIT: DM_WE=1 for exactly 1 clk, then goes to INC if BURST_EN, else DONE.
  - INC: addr_inc=1 for 1 clk. Then goes to RD_LOAD if the frame is a read, else WR_DATA (bit_cnt cleared). Address wraps modulo 2^ADDR_W; wrapping belongs to the address latch.
  - DONE: all outputs 0. Ignores sclk pulses; goes to IDLE on cs==1.
- cs==1 in any non-IDLE state:
  - Next state is IDLE. cs takes priority over a simultaneous sclk pulse.
  - frame_err pulses for 1 clk if the state was ADDR, WR_DATA or RD_OUT with bit_cnt != 0, or was ADDR with bit_cnt==0 after at least one rise.
  - frame_err is not raised for cs rising in DONE, or at a word boundary in burst mode.
- A partial write word is never committed.
- Read-mode latch bit: the frame stays read or write for its whole duration. The R/W bit is latched into a mode flop in LATCH.
- bit_cnt width is clog2(max(ADDR_W+1, DATA_W)+1).
- Timing requirement: an sclk period of at least 4 clk. This guarantees the LATCH→RD_LOAD sequence completes before the first data sclk_fall.
- Simultaneous sclk_rise and sclk_fall pulses are illegal input; the behaviour is undefined.

Decomposition:
- Package spi_ctrl_pkg holds:
  - state enum: IDLE, ADDR, LATCH, RD_LOAD, RD_OUT, WR_DATA, WR_COMMIT, INC, DONE (4-bit encoding);
  - header-length helper function.
- One sub-module, spi_bit_counter: clear, enable, terminal-count compare against a runtime limit, parametrised width.

Test Plan:
1. Reset: assert reset for 2 clk midway through the WR_DATA bits → all outputs 0 next cycle, busy=0, no DM_WE ever. The following frame completes normally.
2. Write: ADDR_W=7, DATA_W=8, sclk period 8 clk, header 0x15 with rw=0, data 0xA5, cs rises after 16 rises.
   - add_WE: one 1-clk pulse after the 8th rise.
   - DM_WE: one 1-clk pulse after the 16th rise.
   - SR_WE=MISO_Buff=0 throughout; frame_err=0.
3. Read: header 0x22 with rw=1.
   - add_WE pulse, then SR_WE pulse on the next clk.
   - MISO_Buff high through exactly 8 sclk_fall pulses, then 0 (DONE, BURST_EN=0).
4. Burst write: BURST_EN=1, 3 data words, then cs high → DM_WE 3 pulses, each followed by an addr_inc pulse (3 total), frame_err=0.
5. Abort: cs rises after 5 data rises of a write → frame_err 1 pulse, no DM_WE, IDLE next clk. A second abort with cs rising during the header also gives frame_err=1.
6. Non-burst overrun: BURST_EN=0, write with 24 rises before cs high → exactly 1 DM_WE, no addr_inc, DONE until cs high.
